// File: rtl/output_drain_buffer.sv
// Output drain buffer: queues three-word groups from the output data shifter and
// serialises them as single channel-tagged words on a valid/ready port.
module output_drain_buffer #(
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH         = 4,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                    clk,
  input  logic                    arst_in,
  input  logic                    in_valid,
  input  logic [31:0]             in_x,
  input  logic [31:0]             in_y,
  input  logic [31:0]             in_ch,
  input  logic [3*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [31:0]             out_x,
  output logic [31:0]             out_y,
  output logic [31:0]             out_ch,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(FIFO_DEPTH - 2);
  localparam logic [PTR_W:0] ONE_C   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [31:0]    NB_CH_C = 32'(OUTPUT_NB_CHANNELS);

  typedef struct packed {
    logic [31:0]             x;
    logic [31:0]             y;
    logic [31:0]             ch;
    logic [3*DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  entry_t                mem_r [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_r;
  logic [PTR_W:0]        rd_ptr_r;
  logic [1:0]            idx_r;
  logic                  overflow_r;
  state_t                state_r;
  state_t                state_s;

  entry_t                head_s;
  logic [PTR_W:0]        count_s;
  logic                  full_s;
  logic [31:0]           word_ch_s;
  logic                  in_range_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  step_s;
  logic                  retire_s;
  logic                  push_s;

  assign head_s     = mem_r[rd_ptr_r[PTR_W-1:0]];
  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign full_s     = (count_s == DEPTH_C);
  assign word_ch_s  = head_s.ch + {30'd0, idx_r};
  assign in_range_s = (word_ch_s < NB_CH_C);

  // A step consumes the current word, either by handshake or by skipping an
  // out-of-range channel; the third step retires the group and frees its slot,
  // which is what lets a push into a full FIFO be accepted in the same cycle.
  assign step_s   = (state_r == EMIT) && (!in_range_s || out_ready);
  assign retire_s = step_s && (idx_r == 2'd2);
  assign push_s   = in_valid && (!full_s || retire_s);

  always_comb begin
    word_s = '0;
    case (idx_r)
      2'd0:    word_s = head_s.data[0 +: DATA_WIDTH];
      2'd1:    word_s = head_s.data[DATA_WIDTH +: DATA_WIDTH];
      2'd2:    word_s = head_s.data[2*DATA_WIDTH +: DATA_WIDTH];
      default: word_s = '0;
    endcase
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if ((count_s != '0) || push_s) begin
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (retire_s && (count_s == ONE_C) && !push_s) begin
          state_s = IDLE;
        end else begin
          state_s = EMIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      idx_r      <= 2'd0;
      overflow_r <= 1'b0;
      state_r    <= IDLE;
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (retire_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      if (step_s) begin
        idx_r <= (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
      end
      if (in_valid && !push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; nothing is observable until a push fills it.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= '{x: in_x, y: in_y, ch: in_ch, data: in_data};
    end
  end

  always_comb begin
    out_valid = (state_r == EMIT) && in_range_s;
    if (out_valid) begin
      out_data = word_s;
      out_x    = head_s.x;
      out_y    = head_s.y;
      out_ch   = word_ch_s;
    end else begin
      out_data = '0;
      out_x    = 32'd0;
      out_y    = 32'd0;
      out_ch   = 32'd0;
    end
  end

  assign almost_full = (count_s >= AF_C);
  assign empty       = (count_s == '0) && (state_r == IDLE);
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_output_drain_buffer.sv
// Directed testbench for output_drain_buffer: single group, back-pressure, channel
// filtering, fill/overflow, full-with-retire and asynchronous reset mid-stream.
module tb_output_drain_buffer;

  logic        clk = 1'b0;
  logic        arst_in;
  logic        in_valid;
  logic [31:0] in_x, in_y, in_ch;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data, out_x, out_y, out_ch;
  logic        almost_full, empty, overflow;

  int passed = 0;
  int total  = 0;

  output_drain_buffer #(
    .DATA_WIDTH(32), .FIFO_DEPTH(4), .OUTPUT_NB_CHANNELS(64)
  ) dut (
    .clk(clk), .arst_in(arst_in), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .almost_full(almost_full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_grp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_ch    = ch;
    in_data  = {w2, w1, w0};
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [31:0] ch,
                          input logic [31:0] x, input logic [31:0] y);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk32({tag, "_data"}, out_data, d);
    chk32({tag, "_ch"}, out_ch, ch);
    chk32({tag, "_x"}, out_x, x);
    chk32({tag, "_y"}, out_y, y);
  endtask

  initial begin
    arst_in   = 1'b1;
    in_valid  = 1'b0;
    in_x      = 32'd0;
    in_y      = 32'd0;
    in_ch     = 32'd0;
    in_data   = 96'd0;
    out_ready = 1'b0;
    #1;
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_af", almost_full, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    chk32("rst_data", out_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_in = 1'b0;
    tick();

    // single group, words present on the three cycles after the push
    out_ready = 1'b1;
    set_grp(32'd5, 32'd2, 32'd0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003);
    tick();
    in_valid = 1'b0;
    chk1("sg_empty_busy", empty, 1'b0);
    chk_word("sg_w0", 32'hAAAA0001, 32'd0, 32'd5, 32'd2);
    tick();
    chk_word("sg_w1", 32'hBBBB0002, 32'd1, 32'd5, 32'd2);
    tick();
    chk_word("sg_w2", 32'hCCCC0003, 32'd2, 32'd5, 32'd2);
    tick();
    chk1("sg_done_valid", out_valid, 1'b0);
    chk1("sg_done_empty", empty, 1'b1);

    // back-pressure holds word 0 and its tags
    out_ready = 1'b0;
    set_grp(32'd7, 32'd9, 32'd10, 32'hD0D0D0D0, 32'hE0E0E0E0, 32'hF0F0F0F0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_word("bp_hold", 32'hD0D0D0D0, 32'd10, 32'd7, 32'd9);
      tick();
    end
    out_ready = 1'b1;
    chk_word("bp_w0", 32'hD0D0D0D0, 32'd10, 32'd7, 32'd9);
    tick();
    chk_word("bp_w1", 32'hE0E0E0E0, 32'd11, 32'd7, 32'd9);
    tick();
    chk_word("bp_w2", 32'hF0F0F0F0, 32'd12, 32'd7, 32'd9);
    tick();
    chk1("bp_empty", empty, 1'b1);

    // channel boundary: only channel 63 is emitted, retirement after 3 cycles
    set_grp(32'd1, 32'd1, 32'd63, 32'h11111111, 32'h22222222, 32'h33333333);
    tick();
    in_valid = 1'b0;
    chk_word("cb_w63", 32'h11111111, 32'd63, 32'd1, 32'd1);
    tick();
    chk1("cb_skip1_valid", out_valid, 1'b0);
    chk1("cb_skip1_empty", empty, 1'b0);
    tick();
    chk1("cb_skip2_valid", out_valid, 1'b0);
    chk1("cb_skip2_empty", empty, 1'b0);
    tick();
    chk1("cb_done_empty", empty, 1'b1);

    // group entirely out of range: silent 3-cycle retirement
    set_grp(32'd2, 32'd2, 32'd100, 32'h44444444, 32'h55555555, 32'h66666666);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("oor_valid", out_valid, 1'b0);
      chk1("oor_busy", empty, 1'b0);
      tick();
    end
    chk1("oor_empty", empty, 1'b1);

    // fill with ready low: 5th group dropped
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      set_grp(32'(g + 1), 32'(g + 20), 32'(3 * g), 32'(g * 16), 32'(g * 16 + 1), 32'(g * 16 + 2));
      tick();
      if (g == 0) chk1("fill_af_after1", almost_full, 1'b0);
      if (g == 1) chk1("fill_af_after2", almost_full, 1'b1);
      if (g == 3) chk1("fill_ovf_after4", overflow, 1'b0);
    end
    in_valid = 1'b0;
    chk1("fill_ovf", overflow, 1'b1);
    chk1("fill_af_full", almost_full, 1'b1);
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      chk_word("fill_drain", 32'((n / 3) * 16 + (n % 3)), 32'(n), 32'((n / 3) + 1), 32'((n / 3) + 20));
      tick();
    end
    chk1("fill_drain_empty", empty, 1'b1);
    chk1("fill_ovf_sticky", overflow, 1'b1);

    // full FIFO, push coincides with retirement of the head group
    arst_in = 1'b1;
    #3;
    arst_in = 1'b0;
    tick();
    chk1("fr_ovf_cleared", overflow, 1'b0);
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++) begin
      set_grp(32'(g + 40), 32'(g + 50), 32'(3 * g), 32'(32'h100 + g * 16), 32'(32'h101 + g * 16), 32'(32'h102 + g * 16));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      chk_word("fr_drain", 32'(32'h100 + (n / 3) * 16 + (n % 3)), 32'(n), 32'((n / 3) + 40), 32'((n / 3) + 50));
      if (n == 2) set_grp(32'd44, 32'd54, 32'd12, 32'h140, 32'h141, 32'h142);
      tick();
      in_valid = 1'b0;
      if (n == 2) chk1("fr_ovf", overflow, 1'b0);
    end
    chk1("fr_empty", empty, 1'b1);

    // asynchronous reset during the second word
    set_grp(32'd3, 32'd4, 32'd20, 32'hABCD0000, 32'hABCD0001, 32'hABCD0002);
    tick();
    in_valid = 1'b0;
    tick();
    chk_word("rm_w1", 32'hABCD0001, 32'd21, 32'd3, 32'd4);
    #1;
    arst_in = 1'b1;
    #1;
    chk1("rm_valid", out_valid, 1'b0);
    chk32("rm_data", out_data, 32'd0);
    chk32("rm_ch", out_ch, 32'd0);
    chk32("rm_x", out_x, 32'd0);
    chk1("rm_empty", empty, 1'b1);
    @(negedge clk);
    arst_in = 1'b0;
    tick();
    chk1("rm_idle_empty", empty, 1'b1);
    set_grp(32'd8, 32'd9, 32'd30, 32'h0000AA00, 32'h0000BB00, 32'h0000CC00);
    tick();
    in_valid = 1'b0;
    chk_word("rm_f0", 32'h0000AA00, 32'd30, 32'd8, 32'd9);
    tick();
    chk_word("rm_f1", 32'h0000BB00, 32'd31, 32'd8, 32'd9);
    tick();
    chk_word("rm_f2", 32'h0000CC00, 32'd32, 32'd8, 32'd9);
    tick();
    chk1("rm_f_empty", empty, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
